// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit and its combinational core.
package logic_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'b000;
  localparam op_t OP_OR    = 3'b001;
  localparam op_t OP_XOR   = 3'b010;
  localparam op_t OP_NOR   = 3'b011;
  localparam op_t OP_XNOR  = 3'b100;
  localparam op_t OP_ANDN  = 3'b101;
  localparam op_t OP_NOTA  = 3'b110;
  localparam op_t OP_PASSB = 3'b111;

  // Bits needed to hold a popcount in the range 0..width.
  function automatic int pop_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the logic unit and writeback.
interface logic_unit_pipe_if import logic_pkg::*; #(
  parameter int WIDTH = 32
);
  localparam int PW = pop_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  op_t              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_parity;
  logic [PW-1:0]    out_popcnt;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_parity, out_popcnt
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_parity, out_popcnt
  );

endinterface

// File: rtl/logic_unit_pipe_core.sv
// Combinational bitwise operation plus zero/parity/popcount flags of the result.
module logic_unit_core import logic_pkg::*; #(
  parameter  int WIDTH = 32,
  localparam int PW    = pop_width(WIDTH)
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_parity,
  output logic [PW-1:0]    o_popcnt
);

  logic [WIDTH-1:0] w_result;
  logic [PW-1:0]    w_popcnt;

  always_comb begin
    w_result = '0;
    case (i_op)
      OP_AND:   w_result = i_a & i_b;
      OP_OR:    w_result = i_a | i_b;
      OP_XOR:   w_result = i_a ^ i_b;
      OP_NOR:   w_result = ~(i_a | i_b);
      OP_XNOR:  w_result = ~(i_a ^ i_b);
      OP_ANDN:  w_result = i_a & ~i_b;
      OP_NOTA:  w_result = ~i_a;
      OP_PASSB: w_result = i_b;
      default:  w_result = '0;
    endcase
  end

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + PW'(w_result[i]);
    end
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == '0);
  assign o_parity = ^w_result;
  assign o_popcnt = w_popcnt;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core with a saturating completion counter.
module logic_unit_pipe import logic_pkg::*; #(
  parameter  int WIDTH       = 32,
  parameter  int COUNT_WIDTH = 16,
  localparam int PW          = pop_width(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  logic_unit_pipe_if.slave       bus,
  output logic [COUNT_WIDTH-1:0] op_count
);

  logic                   r_s1_valid;
  op_t                    r_s1_op;
  logic [WIDTH-1:0]       r_s1_a;
  logic [WIDTH-1:0]       r_s1_b;
  logic                   r_s2_valid;
  logic [WIDTH-1:0]       r_result;
  logic                   r_zero;
  logic                   r_parity;
  logic [PW-1:0]          r_popcnt;
  logic [COUNT_WIDTH-1:0] r_op_count;

  logic                   w_s1_en;
  logic                   w_s2_en;
  logic                   w_out_fire;
  logic [WIDTH-1:0]       w_result;
  logic                   w_zero;
  logic                   w_parity;
  logic [PW-1:0]          w_popcnt;

  // An empty S2 always loads, so bubbles collapse even under backpressure.
  assign w_s2_en    = ~r_s2_valid | bus.out_ready;
  assign w_s1_en    = ~r_s1_valid | w_s2_en;
  assign w_out_fire = r_s2_valid & bus.out_ready;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_parity (w_parity),
    .o_popcnt (w_popcnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_parity   <= 1'b0;
      r_popcnt   <= '0;
      r_op_count <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= bus.in_valid;
        // Operands only load on a real beat so idle-bus garbage never reaches S2.
        if (bus.in_valid) begin
          r_s1_op <= bus.in_op;
          r_s1_a  <= bus.in_a;
          r_s1_b  <= bus.in_b;
        end
      end
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_result;
          r_zero   <= w_zero;
          r_parity <= w_parity;
          r_popcnt <= w_popcnt;
        end
      end
      if (w_out_fire && (r_op_count != '1)) begin
        r_op_count <= r_op_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready   = w_s1_en;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_result;
  assign bus.out_zero   = r_zero;
  assign bus.out_parity = r_parity;
  assign bus.out_popcnt = r_popcnt;
  assign op_count       = r_op_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboarded bench for logic_unit_pipe: one task per scenario, plus a second instance for counter saturation.
module tb_logic_unit_pipe;
  import logic_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        parity;
    logic [5:0]  popcnt;
  } exp_t;

  logic        clk;
  logic        rst0;
  logic        rst1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int errors    = 0;
  int checks    = 0;
  int n_drained = 0;
  exp_t sb[$];

  logic_unit_pipe_if #(.WIDTH(32)) m0 ();
  logic_unit_pipe_if #(.WIDTH(32)) m1 ();

  logic_unit_pipe #(.WIDTH(32), .COUNT_WIDTH(16)) dut0 (
    .clk      (clk),
    .rst      (rst0),
    .bus      (m0.slave),
    .op_count (cnt0)
  );

  logic_unit_pipe #(.WIDTH(32), .COUNT_WIDTH(4)) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .bus      (m1.slave),
    .op_count (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input op_t op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      OP_NOTA:  r = ~a;
      default:  r = b;
    endcase
    e.result = r;
    e.zero   = (r == 32'h0);
    e.parity = ^r;
    e.popcnt = 6'($countones(r));
    return e;
  endfunction

  // Scoreboard for dut0: handshakes are judged mid-cycle, where inputs and state are stable.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst0) begin
      sb.delete();
      n_drained = 0;
    end else begin
      if (m0.out_valid && m0.out_ready) begin
        got = {m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got result=%h with no beat outstanding", m0.out_result);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sb_beat: got res=%h z=%0b p=%0b pc=%0d, want res=%h z=%0b p=%0b pc=%0d",
                     got.result, got.zero, got.parity, got.popcnt,
                     e.result, e.zero, e.parity, e.popcnt);
          end
        end
        n_drained++;
      end
      if (m0.in_valid && m0.in_ready) sb.push_back(model(m0.in_op, m0.in_a, m0.in_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    rst1 = 1'b1;
    m0.in_valid = 1'b0; m0.in_op = OP_AND; m0.in_a = '0; m0.in_b = '0; m0.out_ready = 1'b0;
    m1.in_valid = 1'b0; m1.in_op = OP_AND; m1.in_a = '0; m1.in_b = '0; m1.out_ready = 1'b0;
    tick(); tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    checks++;
    if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", m0.out_valid); end
    checks++;
    if (m0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", m0.in_ready); end
    checks++;
    if ({m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt} !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h z=%0b p=%0b pc=%0d want all 0",
               m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt);
    end
    checks++;
    if (cnt0 !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", cnt0); end
  endtask

  task automatic test_basic_xor();
    m0.out_ready = 1'b1;
    m0.in_valid = 1'b1; m0.in_op = OP_XOR; m0.in_a = 32'd5; m0.in_b = 32'd3;
    tick();
    m0.in_valid = 1'b0; m0.in_a = 32'hDEAD_BEEF; m0.in_b = 32'hFFFF_FFFF;
    checks++;
    if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL xor_early_valid: got %0b want 0", m0.out_valid); end
    tick();
    checks++;
    if ({m0.out_valid, m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt} !==
        {1'b1, 32'd6, 1'b0, 1'b0, 6'd2}) begin
      errors++;
      $display("FAIL xor_result: got v=%0b res=%h z=%0b p=%0b pc=%0d want v=1 res=6 z=0 p=0 pc=2",
               m0.out_valid, m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt);
    end
    tick();
    checks++;
    if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL xor_single_beat: got out_valid %0b want 0", m0.out_valid); end
  endtask

  task automatic test_all_ops();
    logic [31:0] exp_ops [8];
    exp_ops = '{32'h0505_0505, 32'hAFAF_AFAF, 32'hAAAA_AAAA, 32'h5050_5050,
                32'h5555_5555, 32'hA0A0_A0A0, 32'h5A5A_5A5A, 32'h0F0F_0F0F};
    m0.out_ready = 1'b1;
    m0.in_a = 32'hA5A5_A5A5;
    m0.in_b = 32'h0F0F_0F0F;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 8) begin
        m0.in_valid = 1'b1;
        m0.in_op    = op_t'(cyc[2:0]);
      end else begin
        m0.in_valid = 1'b0;
      end
      tick();
      if (cyc >= 1 && cyc <= 8) begin
        checks++;
        if (m0.out_valid !== 1'b1 || m0.out_result !== exp_ops[cyc-1]) begin
          errors++;
          $display("FAIL all_ops[%0d]: got v=%0b res=%h want v=1 res=%h",
                   cyc - 1, m0.out_valid, m0.out_result, exp_ops[cyc-1]);
        end
      end else if (cyc == 9) begin
        checks++;
        if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL all_ops_tail: got out_valid %0b want 0", m0.out_valid); end
      end
    end
  endtask

  task automatic test_zero_full();
    m0.out_ready = 1'b1;
    m0.in_a = 32'h1234_5678;
    m0.in_b = 32'h1234_5678;
    m0.in_valid = 1'b1; m0.in_op = OP_XOR;
    tick();
    m0.in_op = OP_XNOR;
    tick();
    m0.in_valid = 1'b0;
    checks++;
    if ({m0.out_valid, m0.out_result, m0.out_zero, m0.out_popcnt} !== {1'b1, 32'h0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL zero_flag: got v=%0b res=%h z=%0b pc=%0d want v=1 res=0 z=1 pc=0",
               m0.out_valid, m0.out_result, m0.out_zero, m0.out_popcnt);
    end
    tick();
    checks++;
    if ({m0.out_valid, m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt} !==
        {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd32}) begin
      errors++;
      $display("FAIL full_flags: got v=%0b res=%h z=%0b p=%0b pc=%0d want v=1 res=ffffffff z=0 p=0 pc=32",
               m0.out_valid, m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt);
    end
    tick();
    checks++;
    if (cnt0 !== 16'(n_drained)) begin errors++; $display("FAIL op_count_track: got %0d want %0d", cnt0, n_drained); end
  endtask

  task automatic test_backpressure();
    op_t         ops  [4];
    logic [31:0] as   [4];
    logic [31:0] bs   [4];
    exp_t        exps [4];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    ops = '{OP_AND, OP_OR, OP_ANDN, OP_NOTA};
    as  = '{32'hFFFF_0000, 32'h0000_00F0, 32'hC3C3_C3C3, 32'h0000_FFFF};
    bs  = '{32'h0F0F_0F0F, 32'h0000_0F00, 32'h00FF_00FF, 32'h1111_1111};
    for (int i = 0; i < 4; i++) exps[i] = model(ops[i], as[i], bs[i]);
    while (got < 4 && cyc < 40) begin
      m0.out_ready = (cyc >= 6);
      m0.in_valid  = (sent < 4);
      if (sent < 4) begin
        m0.in_op = ops[sent]; m0.in_a = as[sent]; m0.in_b = bs[sent];
      end
      #1;
      if (cyc == 5) begin
        checks++;
        if (m0.in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL bp_in_ready: got in_ready=%0b accepted=%0d want in_ready=0 accepted=2", m0.in_ready, sent);
        end
      end
      if (m0.out_valid && !m0.out_ready) begin
        checks++;
        if ({m0.out_result, m0.out_zero, m0.out_parity, m0.out_popcnt} !== exps[0]) begin
          errors++;
          $display("FAIL bp_hold: got res=%h want res=%h held", m0.out_result, exps[0].result);
        end
      end
      if (m0.out_valid && m0.out_ready) begin
        checks++;
        if (m0.out_result !== exps[got].result) begin
          errors++;
          $display("FAIL bp_order[%0d]: got res=%h want res=%h", got, m0.out_result, exps[got].result);
        end
        got++;
      end
      if (m0.in_valid && m0.in_ready) sent++;
      tick();
      cyc++;
    end
    m0.in_valid = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp_drain: got %0d beats want 4", got); end
    tick();
    checks++;
    if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid %0b want 0", m0.out_valid); end
  endtask

  task automatic test_reset_mid_flight();
    m0.out_ready = 1'b0;
    m0.in_valid = 1'b1; m0.in_op = OP_OR; m0.in_a = 32'h1; m0.in_b = 32'h2;
    tick();
    m0.in_op = OP_XOR;
    tick();
    m0.in_valid = 1'b0;
    checks++;
    if (m0.out_valid !== 1'b1 || m0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_fill: got v=%0b in_ready=%0b want v=1 in_ready=0", m0.out_valid, m0.in_ready);
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    #1;
    checks++;
    if ({m0.out_valid, m0.in_ready, cnt0} !== {1'b0, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL rst_mid_state: got v=%0b in_ready=%0b cnt=%0d want v=0 in_ready=1 cnt=0",
               m0.out_valid, m0.in_ready, cnt0);
    end
    m0.out_ready = 1'b1;
    m0.in_valid = 1'b1; m0.in_op = OP_AND; m0.in_a = 32'hFF00_FF00; m0.in_b = 32'h0FF0_0FF0;
    tick();
    m0.in_valid = 1'b0;
    tick();
    checks++;
    if (m0.out_valid !== 1'b1 || m0.out_result !== 32'h0F00_0F00) begin
      errors++;
      $display("FAIL rst_mid_after: got v=%0b res=%h want v=1 res=0f000f00", m0.out_valid, m0.out_result);
    end
    tick();
  endtask

  task automatic test_saturation();
    int  d = 0;
    int  cyc = 0;
    logic pend;
    m1.out_ready = 1'b1;
    m1.in_valid  = 1'b1;
    m1.in_op     = OP_PASSB;
    while (d < 20 && cyc < 60) begin
      m1.in_b = 32'(cyc);
      #1;
      pend = m1.out_valid && m1.out_ready;
      tick();
      if (pend) d++;
      cyc++;
      checks++;
      if (cnt1 !== 4'((d > 15) ? 15 : d)) begin
        errors++;
        $display("FAIL sat_count: got %0d want %0d after %0d transfers", cnt1, (d > 15) ? 15 : d, d);
      end
    end
    m1.in_valid = 1'b0;
    checks++;
    if (d < 20) begin errors++; $display("FAIL sat_transfers: got %0d want 20", d); end
    tick(); tick(); tick();
    checks++;
    if (cnt1 !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", cnt1); end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    test_reset();
    test_basic_xor();
    test_all_ops();
    test_zero_full();
    test_backpressure();
    test_reset_mid_flight();
    test_saturation();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the ALU's combinational bitwise block.
- Eight selectable bitwise operations on WIDTH-bit operands; output carries registered result plus zero, parity and popcount flags.
- Valid/ready handshake on both sides; sits between ALU operand-fetch and the result-writeback mux.
- Saturating count of completed operations for debug and performance reads.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- COUNT_WIDTH, 16, width of the completed-operation counter (>=1).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  3  operation select (see Behaviour).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result this cycle.
- out_result  out  WIDTH  operation result.
- out_zero  out  1  out_result == 0.
- out_parity  out  1  XOR-reduction of out_result.
- out_popcnt  out  $clog2(WIDTH+1)  number of ones in out_result.
- op_count  out  COUNT_WIDTH  saturating count of accepted output beats.

Behaviour:
- Reset: rst sampled on clk edge. Clears s1_valid, s2_valid, out_result, out_zero, out_parity, out_popcnt, op_count to 0.
  - Reset mid-operation drops all in-flight beats, with no output handshake.
  - in_ready is 1 in the first cycle after reset.
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 ANDN (a & ~b), 110 NOT a, 111 PASS b. All codes are legal.
- Pipeline, two register stages:
  - S1 captures in_op, in_a, in_b.
  - S2 captures the computed result and all flags.
- Enables:
  - s2_en = ~s2_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en (combinational from out_ready and the stage valids only; never from in_valid).
- Transfers:
  - Input transfer: in_valid & in_ready. S1 loads the beat, s1_valid <= 1.
  - When s1_en & ~in_valid: s1_valid <= 0.
  - When s2_en: S2 loads S1's computed values, s2_valid <= s1_valid.
  - out_valid = s2_valid.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 beat per cycle.
  - Bubbles collapse: an empty S2 accepts from S1 even while out_ready = 0.
- Backpressure:
  - While out_valid & ~out_ready, out_result and all flags hold stable.
  - Up to 2 beats are buffered; in_ready falls only when both stages are full and out_ready = 0.
- Simultaneous input accept and output drain in one cycle is legal, with no loss or duplication.
- Flags are computed in S2 from the result. out_popcnt ranges 0..WIDTH.
- Data registers need not clear on reset if the valid bits clear. However, outputs are reset to 0 as listed for a clean waveform.
- op_count:
  - Increments on out_valid & out_ready.
  - Saturates at 2^COUNT_WIDTH-1 and holds; no wrap.
  - Cleared only by rst.
- No X propagation: undefined inputs while in_valid = 0 must not affect outputs.

Decomposition:
- Shared package logic_pkg holds:
  - op-code localparams (OP_AND..OP_PASSB) and the 3-bit op typedef.
  - popcount width function clog2(WIDTH+1).
- Natural sub-module: logic_unit_core. Purely combinational: op, a, b -> result, zero, parity, popcnt. It is instantiated between S1 and S2 and reused by future ALU blocks.
- Pipeline control and op_count stay in logic_unit_pipe.

Test Plan:
- Basic XOR, WIDTH=32: a=5, b=3, op=010, out_ready=1 -> 2 cycles later out_result=6, zero=0, parity=0, popcnt=2.
- All ops sweep: a=0xA5A5A5A5, b=0x0F0F0F0F, one beat per op back-to-back -> results in order:
  - AND 0x05050505, OR 0xAFAFAFAF, XOR 0xAAAAAAAA, NOR 0x50505050,
  - XNOR 0x55555555, ANDN 0xA0A0A0A0, NOT 0x5A5A5A5A, PASS 0x0F0F0F0F.
  - One output per cycle, none dropped.
- Zero/full flags: XOR a=b=0x12345678 -> result 0, zero=1, popcnt=0. XNOR same operands -> 0xFFFFFFFF, popcnt=32, parity=0.
- Backpressure: stream 4 beats with out_ready=0 ->
  - in_ready drops after 2 accepted beats; output holds beat 1 stable.
  - Raising out_ready drains all 4 in order with no duplicates.
- Reset mid-flight: 2 beats in pipe, assert rst one cycle -> next cycle out_valid=0, op_count=0, in_ready=1; a subsequent beat produces a correct result 2 cycles later.
- Counter saturation, COUNT_WIDTH=4: complete 20 output transfers -> op_count reaches 15 and stays 15.
